// File: rtl/gcd_pkg.sv
// gcd_pkg: shared width constant and FSM state type for the GCD request side
package gcd_pkg;
    localparam int GCD_N = 8;
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
endpackage

// File: rtl/gcd_op_fifo.sv
// gcd_op_fifo: operand-pair FIFO; push_i/push_a_i/push_b_i write, pop_i advances head,
// head_a_o/head_b_o show the oldest pair, full_o/empty_o/count_o report occupancy
module gcd_op_fifo
    import gcd_pkg::*;
#(
    parameter int N     = GCD_N,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [N-1:0]             push_a_i,
    input  logic [N-1:0]             push_b_i,
    input  logic                     pop_i,
    output logic [N-1:0]             head_a_o,
    output logic [N-1:0]             head_b_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [2*N-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [AW:0]    cnt_q;
    // memory is reset so the head never presents X to the engine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= {push_a_i, push_b_i};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    assign {head_a_o, head_b_o} = mem_q[rd_q];
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
endmodule

// File: rtl/gcd_requester.sv
// gcd_requester: queues operand pairs, starts the GCD engine per pair, returns results
// in push order on res_valid/res_data/res_ack; zero operands are answered locally (a|b)
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int N     = GCD_N,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    output logic [$clog2(DEPTH):0] count,
    output logic                   eng_start,
    output logic [N-1:0]           eng_ina,
    output logic [N-1:0]           eng_inb,
    input  logic                   eng_ready,
    input  logic [N-1:0]           eng_out,
    output logic                   res_valid,
    output logic [N-1:0]           res_data,
    input  logic                   res_ack
);
    state_e       state_q, state_d;
    logic         res_valid_q, res_valid_d;
    logic [N-1:0] res_data_q, res_data_d;
    logic [N-1:0] head_a, head_b;
    logic         full, empty, pop;
    gcd_op_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (in_valid && !full),
        .push_a_i (in_a),
        .push_b_i (in_b),
        .pop_i    (pop),
        .head_a_o (head_a),
        .head_b_o (head_b),
        .full_o   (full),
        .empty_o  (empty),
        .count_o  (count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end
    // a capture only happens while res_valid_q is low, so it never races an ack
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        eng_start   = 1'b0;
        res_valid_d = res_valid_q && !res_ack;
        res_data_d  = res_data_q;
        if (state_q == IDLE) begin
            if (!empty && !res_valid_q) begin
                if (head_a == '0 || head_b == '0) begin
                    res_data_d  = head_a | head_b;
                    res_valid_d = 1'b1;
                    pop         = 1'b1;
                end else if (eng_ready) begin
                    eng_start = 1'b1;
                    pop       = 1'b1;
                    state_d   = WAIT;
                end
            end
        end else if (eng_ready) begin
            res_data_d  = eng_out;
            res_valid_d = 1'b1;
            state_d     = IDLE;
        end
    end
    assign in_ready  = !full;
    assign eng_ina   = head_a;
    assign eng_inb   = head_b;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: directed table, corner sequences and random traffic against a queue model
module tb_gcd_requester;
    logic       clk, rst, eng_rst;
    logic       in_valid, in_ready, eng_start, eng_ready, res_valid, res_ack;
    logic [7:0] in_a, in_b, eng_ina, eng_inb, eng_out, res_data;
    logic [2:0] count;
    logic [7:0] ex, ey;
    int checks = 0, fails = 0, starts = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] iss_q[$];
    logic        hold = 0;
    logic [7:0]  hold_d = 0;

    gcd_requester dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .count(count), .eng_start(eng_start),
        .eng_ina(eng_ina), .eng_inb(eng_inb), .eng_ready(eng_ready),
        .eng_out(eng_out), .res_valid(res_valid), .res_data(res_data),
        .res_ack(res_ack)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // subtractive GCD engine: ready drops on load, rises when the operands meet
    always @(posedge clk or posedge eng_rst) begin
        if (eng_rst) begin
            ex <= 0; ey <= 0; eng_ready <= 1;
        end else if (eng_start) begin
            ex <= eng_ina; ey <= eng_inb; eng_ready <= 0;
        end else if (!eng_ready) begin
            if (ex == ey) eng_ready <= 1;
            else if (ex > ey) ex <= ex - ey;
            else ey <= ey - ex;
        end
    end
    assign eng_out = ex;

    function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] t;
        while (b != 0) begin
            t = a % b; a = b; b = t;
        end
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    // scoreboard: results in push order, engine issues in push order of nonzero pairs
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete(); iss_q.delete(); hold = 0;
        end else begin
            if (hold) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, hold_d);
            end
            hold   = res_valid && !res_ack;
            hold_d = res_data;
            if (eng_start) begin
                starts++;
                chk("start_ready", eng_ready, 1);
                if (iss_q.size() == 0) chk("start_unexpected", 1, 0);
                else chk("start_operands", {eng_ina, eng_inb}, iss_q.pop_front());
            end
            if (res_valid && res_ack) begin
                if (exp_q.size() == 0) chk("result_unexpected", 1, 0);
                else chk("result_order", res_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_gcd(in_a, in_b));
                if (in_a != 0 && in_b != 0) iss_q.push_back({in_a, in_b});
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        @(posedge clk); #1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        chk("push_ready", in_ready, 1);
        in_valid = 1; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!res_valid && n < limit);
        chk("valid_timeout", res_valid, 1);
    endtask

    task automatic drain();
        int t = 0;
        in_valid = 0; res_ack = 1;
        while ((exp_q.size() != 0 || count != 0) && t < 3000) begin
            @(negedge clk); t++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    typedef struct { logic [7:0] a, b, exp; int lat; } vec_t;
    vec_t vecs[14];

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int n, s0;
        vecs[0]  = '{12, 18, 6, 0};  vecs[1]  = '{21, 6, 3, 0};
        vecs[2]  = '{7, 7, 7, 4};    vecs[3]  = '{0, 5, 5, 2};
        vecs[4]  = '{0, 0, 0, 2};    vecs[5]  = '{9, 6, 3, 0};
        vecs[6]  = '{10, 4, 2, 0};   vecs[7]  = '{8, 12, 4, 0};
        vecs[8]  = '{15, 5, 5, 0};   vecs[9]  = '{14, 21, 7, 0};
        vecs[10] = '{255, 1, 1, 0};  vecs[11] = '{4, 6, 2, 0};
        vecs[12] = '{0, 9, 9, 2};    vecs[13] = '{200, 0, 200, 2};
        rst = 1; eng_rst = 1; in_valid = 0; in_a = 0; in_b = 0; res_ack = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0; eng_rst = 0;
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_eng_start", eng_start, 0);

        res_ack = 1;
        foreach (vecs[v]) begin
            push(vecs[v].a, vecs[v].b);
            n = 0;
            do begin
                @(negedge clk); n++;
                if (n == 1) begin
                    chk("vec_start", eng_start, int'(vecs[v].a != 0 && vecs[v].b != 0));
                    if (eng_start) begin
                        chk("vec_ina", eng_ina, vecs[v].a);
                        chk("vec_inb", eng_inb, vecs[v].b);
                    end
                end
            end while (!res_valid && n < 400);
            chk("vec_data", res_data, vecs[v].exp);
            if (vecs[v].lat != 0) chk("vec_latency", n, vecs[v].lat);
        end
        drain();

        res_ack = 0; s0 = starts;
        push(9, 6); push(10, 4); push(8, 12); push(15, 5); push(14, 21);
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        wait_valid(100, n);
        chk("held_data", res_data, 3);
        @(posedge clk); #1;
        in_valid = 1; in_a = 3; in_b = 9;
        repeat (3) begin
            @(negedge clk);
            chk("blocked_count", count, 4);
            chk("blocked_in_ready", in_ready, 0);
        end
        chk("held_starts", starts - s0, 1);
        @(posedge clk); #1 res_ack = 1;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!in_ready && n < 50);
        chk("sixth_accept", in_ready, 1);
        @(posedge clk); #1 in_valid = 0;
        drain();

        push(255, 1); push(6, 9); push(10, 15);
        @(negedge clk);
        chk("wait_count", count, 2);
        @(posedge clk); #1 rst = 1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        @(posedge clk); #1 rst = 0;
        push(4, 6);
        wait_valid(600, n);
        chk("after_rst_data", res_data, 2);
        drain();

        res_ack = 0;
        push(0, 3); push(8, 4); push(9, 3);
        @(negedge clk);
        chk("pp_setup_count", count, 2);
        @(posedge clk); #1 res_ack = 1;
        @(posedge clk); #1;
        in_valid = 1; in_a = 6; in_b = 4;
        @(negedge clk);
        chk("pp_pop", eng_start, 1);
        chk("pp_count_before", count, 2);
        @(posedge clk); #1 in_valid = 0;
        chk("pp_count_after", count, 2);
        drain();

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom % 2);
            in_a = ($urandom % 6 == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            in_b = ($urandom % 6 == 0) ? 8'd0 : 8'($urandom_range(1, 40));
            res_ack = ($urandom % 3 != 0);
        end
        @(posedge clk); #1;
        drain();
        repeat (2) @(negedge clk);
        chk("final_res_valid", res_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
